// File: rtl/mem_wb_pipe_nlane.sv
// MEM->WB pipeline register for the N-issue core.
// Per-lane valid, stall/flush, x0 and intra-bundle WAW write squashing.
module mem_wb_pipe_nlane #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        valid_mem,
  input  logic [LANES-1:0]        regwrite_mem,
  input  logic [LANES*REG_AW-1:0] dest_reg_mem,
  input  logic [LANES*DATA_W-1:0] wdata_mem,
  input  logic [LANES*PC_W-1:0]   pc_plus1_mem,
  output logic [LANES-1:0]        valid_wb,
  output logic [LANES-1:0]        regwrite_wb,
  output logic [LANES*REG_AW-1:0] dest_reg_wb,
  output logic [LANES*DATA_W-1:0] wdata_wb,
  output logic [LANES*PC_W-1:0]   pc_plus1_wb,
  output logic [CNT_W-1:0]        retire_cnt
);

  logic [LANES-1:0] kill;
  logic [LANES-1:0] regwrite_nxt;
  logic [CNT_W-1:0] retire_inc;

  // Older lane loses its write to any younger lane writing the same reg.
  always_comb begin
    kill = '0;
    regwrite_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (valid_mem[j] && regwrite_mem[j] &&
            dest_reg_mem[j*REG_AW +: REG_AW] ==
            dest_reg_mem[i*REG_AW +: REG_AW])
          kill[i] = 1'b1;
      end
      regwrite_nxt[i] = valid_mem[i] & regwrite_mem[i] &
                        (dest_reg_mem[i*REG_AW +: REG_AW] != '0) &
                        ~kill[i];
    end
  end

  // Number of real instructions entering WB this cycle.
  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < LANES; i++)
      retire_inc = retire_inc + CNT_W'(valid_mem[i]);
  end

  // Stage register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_wb    <= '0;
      regwrite_wb <= '0;
      dest_reg_wb <= '0;
      wdata_wb    <= '0;
      pc_plus1_wb <= '0;
      retire_cnt  <= '0;
    end else if (flush) begin
      valid_wb    <= '0;
      regwrite_wb <= '0;
      dest_reg_wb <= '0;
      wdata_wb    <= '0;
      pc_plus1_wb <= '0;
    end else if (!stall) begin
      valid_wb    <= valid_mem;
      regwrite_wb <= regwrite_nxt;
      dest_reg_wb <= dest_reg_mem;
      wdata_wb    <= wdata_mem;
      pc_plus1_wb <= pc_plus1_mem;
      retire_cnt  <= retire_cnt + retire_inc;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe_nlane.sv
// Scoreboard bench for mem_wb_pipe_nlane.
// Three instances: default, CNT_W=4 and LANES=4.
module tb_mem_wb_pipe_nlane;

  typedef struct {
    int           id;
    int           num;
    logic [3:0]   v;
    logic [3:0]   rw;
    logic [19:0]  d;
    logic [127:0] wd;
    logic [31:0]  pc;
    logic [31:0]  cnt;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int seq = 0;
  rec_t q0[$], q1[$], q2[$];

  // DUT 0: defaults
  logic r0 = 1, s0 = 0, f0 = 0;
  logic [1:0] vm0 = 0, rm0 = 0;
  logic [9:0] dm0 = 0;
  logic [63:0] wm0 = 0;
  logic [15:0] pm0 = 0;
  logic [1:0] vw0, rw0;
  logic [9:0] dw0;
  logic [63:0] ww0;
  logic [15:0] pw0;
  logic [31:0] c0;

  // DUT 1: 4-bit counter
  logic r1 = 1, s1 = 0, f1 = 0;
  logic [1:0] vm1 = 0, rm1 = 0;
  logic [9:0] dm1 = 0;
  logic [63:0] wm1 = 0;
  logic [15:0] pm1 = 0;
  logic [1:0] vw1, rw1;
  logic [9:0] dw1;
  logic [63:0] ww1;
  logic [15:0] pw1;
  logic [3:0] c1;

  // DUT 2: four lanes
  logic r2 = 1, s2 = 0, f2 = 0;
  logic [3:0] vm2 = 0, rm2 = 0;
  logic [19:0] dm2 = 0;
  logic [127:0] wm2 = 0;
  logic [31:0] pm2 = 0;
  logic [3:0] vw2, rw2;
  logic [19:0] dw2;
  logic [127:0] ww2;
  logic [31:0] pw2;
  logic [31:0] c2;

  mem_wb_pipe_nlane u0 (
    .clk(clk), .reset(r0), .stall(s0), .flush(f0),
    .valid_mem(vm0), .regwrite_mem(rm0),
    .dest_reg_mem(dm0), .wdata_mem(wm0),
    .pc_plus1_mem(pm0),
    .valid_wb(vw0), .regwrite_wb(rw0),
    .dest_reg_wb(dw0), .wdata_wb(ww0),
    .pc_plus1_wb(pw0), .retire_cnt(c0)
  );

  mem_wb_pipe_nlane #(.CNT_W(4)) u1 (
    .clk(clk), .reset(r1), .stall(s1), .flush(f1),
    .valid_mem(vm1), .regwrite_mem(rm1),
    .dest_reg_mem(dm1), .wdata_mem(wm1),
    .pc_plus1_mem(pm1),
    .valid_wb(vw1), .regwrite_wb(rw1),
    .dest_reg_wb(dw1), .wdata_wb(ww1),
    .pc_plus1_wb(pw1), .retire_cnt(c1)
  );

  mem_wb_pipe_nlane #(.LANES(4)) u2 (
    .clk(clk), .reset(r2), .stall(s2), .flush(f2),
    .valid_mem(vm2), .regwrite_mem(rm2),
    .dest_reg_mem(dm2), .wdata_mem(wm2),
    .pc_plus1_mem(pm2),
    .valid_wb(vw2), .regwrite_wb(rw2),
    .dest_reg_wb(dw2), .wdata_wb(ww2),
    .pc_plus1_wb(pw2), .retire_cnt(c2)
  );

  task automatic compare(input rec_t e, input rec_t a);
    vectors++;
    if (a.v !== e.v || a.rw !== e.rw || a.d !== e.d ||
        a.wd !== e.wd || a.pc !== e.pc || a.cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL dut%0d/v%0d: got v=%h rw=%h d=%h wd=%h pc=%h cnt=%h exp v=%h rw=%h d=%h wd=%h pc=%h cnt=%h",
               e.id, e.num, a.v, a.rw, a.d, a.wd, a.pc, a.cnt,
               e.v, e.rw, e.d, e.wd, e.pc, e.cnt);
    end
  endtask

  // Monitors: pop one expectation per edge whenever one is pending.
  always begin
    rec_t e, a;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a.id = 0; a.num = 0;
      a.v = {2'b0, vw0}; a.rw = {2'b0, rw0};
      a.d = {10'b0, dw0}; a.wd = {64'b0, ww0};
      a.pc = {16'b0, pw0}; a.cnt = c0;
      compare(e, a);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a.id = 1; a.num = 0;
      a.v = {2'b0, vw1}; a.rw = {2'b0, rw1};
      a.d = {10'b0, dw1}; a.wd = {64'b0, ww1};
      a.pc = {16'b0, pw1}; a.cnt = {28'b0, c1};
      compare(e, a);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a.id = 2; a.num = 0;
      a.v = vw2; a.rw = rw2; a.d = dw2; a.wd = ww2;
      a.pc = pw2; a.cnt = c2;
      compare(e, a);
    end
  end

  task automatic step(
    input int id, input logic rs, st, fl,
    input logic [3:0] v, rw, input logic [19:0] d,
    input logic [127:0] wd, input logic [31:0] pc,
    input logic [3:0] ev, erw, input logic [19:0] ed,
    input logic [127:0] ewd, input logic [31:0] epc, ecnt);
    rec_t e;
    @(negedge clk);
    seq++;
    e.id = id; e.num = seq;
    e.v = ev; e.rw = erw; e.d = ed; e.wd = ewd;
    e.pc = epc; e.cnt = ecnt;
    case (id)
      0: begin
        r0 = rs; s0 = st; f0 = fl; vm0 = v[1:0]; rm0 = rw[1:0];
        dm0 = d[9:0]; wm0 = wd[63:0]; pm0 = pc[15:0];
        q0.push_back(e);
      end
      1: begin
        r1 = rs; s1 = st; f1 = fl; vm1 = v[1:0]; rm1 = rw[1:0];
        dm1 = d[9:0]; wm1 = wd[63:0]; pm1 = pc[15:0];
        q1.push_back(e);
      end
      default: begin
        r2 = rs; s2 = st; f2 = fl; vm2 = v; rm2 = rw;
        dm2 = d; wm2 = wd; pm2 = pc;
        q2.push_back(e);
      end
    endcase
  endtask

  initial begin
    logic [127:0] rw128;
    // reset with random inputs
    for (int k = 0; k < 2; k++) begin
      rw128 = {$urandom, $urandom, $urandom, $urandom};
      step(0, 1, $urandom_range(1), $urandom_range(1),
           4'($urandom), 4'($urandom), 20'($urandom), rw128, $urandom,
           0, 0, 0, 0, 0, 0);
    end
    // basic load
    step(0, 0, 0, 0, 4'b11, 4'b11, 20'h083, {32'hB, 32'hA}, 32'h1110,
         4'b11, 4'b11, 20'h083, {32'hB, 32'hA}, 32'h1110, 2);
    // same-dest WAW: younger wins
    step(0, 0, 0, 0, 4'b11, 4'b11, 20'h0E7, {32'hD, 32'hC}, 32'h1312,
         4'b11, 4'b10, 20'h0E7, {32'hD, 32'hC}, 32'h1312, 4);
    // x0 dest on lane 0, invalid lane 1
    step(0, 0, 0, 0, 4'b01, 4'b11, 20'h0A0, {32'hF, 32'hE}, 32'h1514,
         4'b01, 4'b00, 20'h0A0, {32'hF, 32'hE}, 32'h1514, 5);
    // stall 3 cycles with changing inputs
    for (int k = 0; k < 3; k++)
      step(0, 0, 1, 0, 4'b11, 4'b11, 20'(k + 33), 128'(k + 7), 32'(k),
           4'b01, 4'b00, 20'h0A0, {32'hF, 32'hE}, 32'h1514, 5);
    // stall and flush together: flush wins
    step(0, 0, 1, 1, 4'b11, 4'b11, 20'h0E7, {32'h5, 32'h6}, 32'h7777,
         0, 0, 0, 0, 0, 5);
    // only lane 1 valid
    step(0, 0, 0, 0, 4'b10, 4'b10, 20'h0C2, {32'h22, 32'h21}, 32'h3130,
         4'b10, 4'b10, 20'h0C2, {32'h22, 32'h21}, 32'h3130, 6);
    // same dest, younger not writing: older keeps its write
    step(0, 0, 0, 0, 4'b11, 4'b01, 20'h108, {32'h2, 32'h1}, 32'h4140,
         4'b11, 4'b01, 20'h108, {32'h2, 32'h1}, 32'h4140, 8);
    // valid_wb=11 then reset during stall
    step(0, 0, 0, 0, 4'b11, 4'b00, 20'h022, {32'h4, 32'h3}, 32'h5150,
         4'b11, 4'b00, 20'h022, {32'h4, 32'h3}, 32'h5150, 10);
    step(0, 1, 1, 0, 4'b11, 4'b11, 20'h0E7, {32'h9, 32'h9}, 32'h9999,
         0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 4'b11, 4'b11, 20'h0E7, {32'h9, 32'h9}, 32'h9999,
         0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4'b11, 4'b11, 20'h0E7, {32'h9, 32'h9}, 32'h9999,
         0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 4'b01, 4'b01, 20'h009, {32'h0, 32'h99}, 32'h0060,
         4'b01, 4'b01, 20'h009, {32'h0, 32'h99}, 32'h0060, 1);

    // counter wrap on CNT_W=4
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++)
      step(1, 0, 0, 0, 4'b01, 4'b00, 0, 0, 0,
           4'b01, 4'b00, 0, 0, 0, 32'(k));
    step(1, 0, 0, 0, 4'b11, 4'b00, 0, 0, 0,
         4'b11, 4'b00, 0, 0, 0, 1);

    // four lanes, lanes 0/2/3 share dest 7, lane 1 dest 5
    step(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 4'b1111, 4'b1111, 20'h39CA7,
         {32'h4, 32'h3, 32'h2, 32'h1}, 32'h03020100,
         4'b1111, 4'b1010, 20'h39CA7,
         {32'h4, 32'h3, 32'h2, 32'h1}, 32'h03020100, 4);
    // lane 3 invalid: lane 2 now wins
    step(2, 0, 0, 0, 4'b0111, 4'b1111, 20'h39CA7,
         {32'h8, 32'h7, 32'h6, 32'h5}, 32'h07060504,
         4'b0111, 4'b0110, 20'h39CA7,
         {32'h8, 32'h7, 32'h6, 32'h5}, 32'h07060504, 7);

    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending exp 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
